// File: rtl/decoder_pkg.sv
// Shared opcode encodings and FSM state type for the multicycle decoder.
package decoder_pkg;

  // Base 3-bit encodings; the decoder zero-extends these to its opcode width.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULI = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    WAIT_SW  = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mc_counter.sv
// Saturating down-counter that times the remaining MULI execute cycles.
module mc_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/multicycle_decoder.sv
// Mealy control decoder: single-cycle ops in EXEC, stalls for the switch operand
// (WAIT_SW) and for multi-cycle multiply-immediate (MUL_WAIT).
module multicycle_decoder
  import decoder_pkg::*;
#(
  parameter int OPW        = 3,
  parameter int ALUW       = 2,
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [OPW-1:0]  opcode,
  input  logic            sw_valid,
  output logic [ALUW-1:0] ALUFunc,
  output logic            PCincr,
  output logic            imm,
  output logic            imm_or_sw,
  output logic            write,
  output logic            sw_ack,
  output logic            busy,
  output logic            illegal
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;
  // First MUL_WAIT cycle counts from MUL_CYCLES-2 down; the zero cycle writes.
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_CYCLES >= 2) ? (MUL_CYCLES - 2) : 0);

  state_t          state, state_nxt;
  logic [ALUW-1:0] alu_q, alu_nxt;
  logic            cnt_load, cnt_dec, cnt_zero;

  mc_counter #(
    .W(CW)
  ) u_mc_counter (
    .clk     (clk),
    .nReset  (nReset),
    .load    (cnt_load),
    .load_val(MUL_LOAD),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // FSM state and captured ALU function of a stalled instruction.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= EXEC;
      alu_q <= '0;
    end else begin
      state <= state_nxt;
      alu_q <= alu_nxt;
    end
  end

  // Mealy decode of outputs and next state; everything forced low during reset.
  always_comb begin
    state_nxt = state;
    alu_nxt   = alu_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    ALUFunc   = '0;
    PCincr    = 1'b0;
    imm       = 1'b0;
    imm_or_sw = 1'b0;
    write     = 1'b0;
    sw_ack    = 1'b0;
    busy      = 1'b0;
    illegal   = 1'b0;
    if (nReset) begin
      unique case (state)
        EXEC: begin
          ALUFunc = opcode[ALUW-1:0];
          case (opcode)
            OPW'(OP_NOP): begin
              PCincr = 1'b1;
            end
            OPW'(OP_ADD): begin
              PCincr = 1'b1;
              write  = 1'b1;
            end
            OPW'(OP_ADDI): begin
              PCincr    = 1'b1;
              write     = 1'b1;
              imm       = 1'b1;
              imm_or_sw = 1'b1;
            end
            OPW'(OP_LOAD): begin
              if (sw_valid) begin
                PCincr = 1'b1;
                write  = 1'b1;
                imm    = 1'b1;
                sw_ack = 1'b1;
              end else begin
                state_nxt = WAIT_SW;
                alu_nxt   = opcode[ALUW-1:0];
              end
            end
            OPW'(OP_MULI): begin
              imm       = 1'b1;
              imm_or_sw = 1'b1;
              if (MUL_CYCLES == 1) begin
                PCincr = 1'b1;
                write  = 1'b1;
              end else begin
                cnt_load  = 1'b1;
                state_nxt = MUL_WAIT;
                alu_nxt   = opcode[ALUW-1:0];
              end
            end
            default: begin
              PCincr  = 1'b1;
              illegal = 1'b1;
            end
          endcase
        end
        WAIT_SW: begin
          busy    = 1'b1;
          ALUFunc = alu_q;
          if (sw_valid) begin
            PCincr    = 1'b1;
            write     = 1'b1;
            imm       = 1'b1;
            sw_ack    = 1'b1;
            state_nxt = EXEC;
          end
        end
        MUL_WAIT: begin
          busy      = 1'b1;
          ALUFunc   = alu_q;
          imm       = 1'b1;
          imm_or_sw = 1'b1;
          if (cnt_zero) begin
            PCincr    = 1'b1;
            write     = 1'b1;
            state_nxt = EXEC;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_nxt = EXEC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench: one DUT with MUL_CYCLES=3, one with MUL_CYCLES=1, shared stimulus.
module tb_multicycle_decoder;

  logic       clk = 1'b0;
  logic       nReset;
  logic [2:0] opcode;
  logic       sw_valid;

  logic [1:0] a_alu, b_alu;
  logic a_pc, a_imm, a_ios, a_wr, a_ack, a_busy, a_ill;
  logic b_pc, b_imm, b_ios, b_wr, b_ack, b_busy, b_ill;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard entry: {dut select (0 = MUL3, 1 = MUL1), expected output vector}.
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  multicycle_decoder #(.OPW(3), .ALUW(2), .MUL_CYCLES(3)) dut3 (
    .clk(clk), .nReset(nReset), .opcode(opcode), .sw_valid(sw_valid),
    .ALUFunc(a_alu), .PCincr(a_pc), .imm(a_imm), .imm_or_sw(a_ios),
    .write(a_wr), .sw_ack(a_ack), .busy(a_busy), .illegal(a_ill)
  );

  multicycle_decoder #(.OPW(3), .ALUW(2), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .nReset(nReset), .opcode(opcode), .sw_valid(sw_valid),
    .ALUFunc(b_alu), .PCincr(b_pc), .imm(b_imm), .imm_or_sw(b_ios),
    .write(b_wr), .sw_ack(b_ack), .busy(b_busy), .illegal(b_ill)
  );

  // Vector order: PCincr write imm imm_or_sw sw_ack busy illegal ALUFunc[1:0]
  function automatic logic [8:0] ev(input logic pc, input logic wr, input logic im,
                                    input logic ios, input logic ack, input logic bs,
                                    input logic il, input logic [1:0] alu);
    return {pc, wr, im, ios, ack, bs, il, alu};
  endfunction

  function automatic logic [8:0] obs(input logic which);
    if (which) return {b_pc, b_wr, b_imm, b_ios, b_ack, b_busy, b_ill, b_alu};
    return {a_pc, a_wr, a_imm, a_ios, a_ack, a_busy, a_ill, a_alu};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    nReset = 1'b0; opcode = 3'b010; sw_valid = 1'b1;
    #2;
    sb.push_back({1'b0, 9'd0});
    e = sb.pop_front(); n_cmp++;
    if (obs(e[9]) !== e[8:0]) begin
      n_bad++; $display("FAIL reset_dut3: got %b want %b", obs(e[9]), e[8:0]);
    end
    sb.push_back({1'b1, 9'd0});
    e = sb.pop_front(); n_cmp++;
    if (obs(e[9]) !== e[8:0]) begin
      n_bad++; $display("FAIL reset_dut1: got %b want %b", obs(e[9]), e[8:0]);
    end
    opcode = 3'b000; sw_valid = 1'b0;
    @(negedge clk); nReset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq();
    logic [2:0] op[3];
    logic [8:0] ex[3];
    logic [9:0] e;
    op = '{3'b010, 3'b001, 3'b000};
    ex[0] = ev(1, 1, 0, 0, 0, 0, 0, 2'b10);
    ex[1] = ev(1, 1, 1, 1, 0, 0, 0, 2'b01);
    ex[2] = ev(1, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      opcode = op[i]; sw_valid = 1'b0; sb.push_back({1'b0, ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL seq[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [2:0] op[6];
    logic       sw[6];
    logic [8:0] ex[6];
    logic [9:0] e;
    op = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    sw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ex[0] = ev(0, 0, 0, 0, 0, 0, 0, 2'b00);
    ex[1] = ev(0, 0, 0, 0, 0, 1, 0, 2'b00);
    ex[2] = ev(0, 0, 0, 0, 0, 1, 0, 2'b00);
    ex[3] = ev(0, 0, 0, 0, 0, 1, 0, 2'b00);
    ex[4] = ev(1, 1, 1, 0, 1, 1, 0, 2'b00);
    ex[5] = ev(1, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      opcode = op[i]; sw_valid = sw[i]; sb.push_back({1'b0, ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL load_wait[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muli3();
    logic [2:0] op[4];
    logic       sw[4];
    logic [8:0] ex[4];
    logic [9:0] e;
    op = '{3'b011, 3'b000, 3'b000, 3'b000};
    sw = '{1'b0, 1'b1, 1'b1, 1'b0};  // sw_valid during MUL_WAIT must not be acked
    ex[0] = ev(0, 0, 1, 1, 0, 0, 0, 2'b11);
    ex[1] = ev(0, 0, 1, 1, 0, 1, 0, 2'b11);
    ex[2] = ev(1, 1, 1, 1, 0, 1, 0, 2'b11);
    ex[3] = ev(1, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      opcode = op[i]; sw_valid = sw[i]; sb.push_back({1'b0, ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL muli3[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muli1();
    logic [2:0] op[4];
    logic       wh[4];
    logic [8:0] ex[4];
    logic [9:0] e;
    op = '{3'b011, 3'b001, 3'b000, 3'b000};
    wh = '{1'b1, 1'b1, 1'b0, 1'b0};
    ex[0] = ev(1, 1, 1, 1, 0, 0, 0, 2'b11);
    ex[1] = ev(1, 1, 1, 1, 0, 0, 0, 2'b01);
    ex[2] = ev(1, 1, 1, 1, 0, 1, 0, 2'b11);  // MUL3 instance finishing its MULI
    ex[3] = ev(1, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      opcode = op[i]; sw_valid = 1'b0; sb.push_back({wh[i], ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL muli1[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [2:0] op[3];
    logic       wh[3];
    logic [8:0] ex[3];
    logic [9:0] e;
    op = '{3'b111, 3'b101, 3'b110};
    wh = '{1'b0, 1'b0, 1'b1};
    ex[0] = ev(1, 0, 0, 0, 0, 0, 1, 2'b11);
    ex[1] = ev(1, 0, 0, 0, 0, 0, 1, 2'b01);
    ex[2] = ev(1, 0, 0, 0, 0, 0, 1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      opcode = op[i]; sw_valid = 1'b0; sb.push_back({wh[i], ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL illegal[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op[4];
    logic       sw[4];
    logic [8:0] ex[4];
    logic [9:0] e;
    op = '{3'b100, 3'b100, 3'b100, 3'b000};
    sw = '{1'b1, 1'b1, 1'b1, 1'b0};
    ex[0] = ev(1, 1, 1, 0, 1, 0, 0, 2'b00);
    ex[1] = ev(1, 1, 1, 0, 1, 0, 0, 2'b00);
    ex[2] = ev(1, 1, 1, 0, 1, 0, 0, 2'b00);
    ex[3] = ev(1, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      opcode = op[i]; sw_valid = sw[i]; sb.push_back({1'b0, ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL b2b_load[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_muli();
    logic [2:0] op[2];
    logic [8:0] ex[2];
    logic [9:0] e;
    op = '{3'b011, 3'b000};
    ex[0] = ev(0, 0, 1, 1, 0, 0, 0, 2'b11);
    ex[1] = ev(0, 0, 1, 1, 0, 1, 0, 2'b11);
    for (int i = 0; i < 2; i++) begin
      opcode = op[i]; sw_valid = 1'b0; sb.push_back({1'b0, ex[i]});
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs(e[9]) !== e[8:0]) begin
        n_bad++; $display("FAIL rst_muli[%0d]: got %b want %b", i, obs(e[9]), e[8:0]);
      end
      @(posedge clk); #1;
    end
    // Final MUL_WAIT cycle would write; reset must kill it without a clock edge.
    nReset = 1'b0;
    #1;
    sb.push_back({1'b0, 9'd0});
    e = sb.pop_front(); n_cmp++;
    if (obs(e[9]) !== e[8:0]) begin
      n_bad++; $display("FAIL rst_muli_async: got %b want %b", obs(e[9]), e[8:0]);
    end
    @(posedge clk);
    @(negedge clk); nReset = 1'b1;
    @(posedge clk); #1;
    opcode = 3'b010; sw_valid = 1'b0;
    sb.push_back({1'b0, ev(1, 1, 0, 0, 0, 0, 0, 2'b10)});
    @(negedge clk);
    e = sb.pop_front(); n_cmp++;
    if (obs(e[9]) !== e[8:0]) begin
      n_bad++; $display("FAIL rst_muli_exec: got %b want %b", obs(e[9]), e[8:0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_load_wait();
    test_muli3();
    test_muli1();
    test_illegal();
    test_back_to_back();
    test_reset_mid_muli();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
